// File: rtl/seq_barrel_shifter.sv
// Iterative multi-mode shifter: applies one log2 barrel stage per clock
// (SLL/SRL/SRA/ROL/ROR) behind valid/ready handshakes on both sides.
module seq_barrel_shifter #(
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned CNTW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNTW-1:0]  in_cnt,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             busy
);

  localparam logic [2:0] MODE_SLL = 3'b000;
  localparam logic [2:0] MODE_SRL = 3'b001;
  localparam logic [2:0] MODE_SRA = 3'b010;
  localparam logic [2:0] MODE_ROL = 3'b011;
  localparam logic [2:0] MODE_ROR = 3'b100;

  localparam logic [CNTW-1:0] LAST_STAGE = CNTW'(CNTW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  work_q, work_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [2:0]        mode_q, mode_d;
  logic              sign_q, sign_d;
  logic [CNTW-1:0]   stage_q, stage_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              out_err_q, out_err_d;
  logic              busy_q, busy_d;

  logic [CNTW-1:0]   amt_c;
  logic [CNTW-1:0]   rev_c;
  logic [WIDTH-1:0]  ones_c;
  logic [WIDTH-1:0]  fill_c;
  logic [WIDTH-1:0]  stage_out_c;
  logic              stage_bit_c;

  // One barrel stage: shift/rotate the working register by 2^stage.
  // rev_c = WIDTH - amt, computed modulo 2^CNTW since WIDTH is a power of two.
  always_comb begin
    amt_c       = CNTW'(1) << stage_q;
    rev_c       = CNTW'(0) - amt_c;
    ones_c      = '1;
    fill_c      = sign_q ? ~(ones_c >> amt_c) : '0;
    stage_bit_c = 1'b0;
    for (int unsigned k = 0; k < CNTW; k++) begin
      if (stage_q == CNTW'(k)) stage_bit_c = cnt_q[k];
    end
    case (mode_q)
      MODE_SLL: stage_out_c = work_q << amt_c;
      MODE_SRL: stage_out_c = work_q >> amt_c;
      MODE_SRA: stage_out_c = (work_q >> amt_c) | fill_c;
      MODE_ROL: stage_out_c = (work_q << amt_c) | (work_q >> rev_c);
      MODE_ROR: stage_out_c = (work_q >> amt_c) | (work_q << rev_c);
      default:  stage_out_c = work_q;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    sign_d      = sign_q;
    stage_d     = stage_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_err_d   = out_err_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d     = in_data;
          cnt_d      = in_cnt;
          mode_d     = in_mode;
          sign_d     = in_data[WIDTH-1];
          stage_d    = '0;
          out_err_d  = (in_mode > MODE_ROR);
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (stage_bit_c) work_d = stage_out_c;
        stage_d = stage_q + CNTW'(1);
        if (stage_q == LAST_STAGE) begin
          stage_d     = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_err_d   = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        out_err_d   = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
        stage_d     = '0;
      end
    endcase
  end

  // State register; reset abandons any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      work_q      <= '0;
      cnt_q       <= '0;
      mode_q      <= '0;
      sign_q      <= 1'b0;
      stage_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      sign_q      <= sign_d;
      stage_q     <= stage_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = work_q;
  assign out_err   = out_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_seq_barrel_shifter.sv
// Directed bench for seq_barrel_shifter (WIDTH=16, four stages).
module tb_seq_barrel_shifter;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNTW  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [CNTW-1:0]  in_cnt;
  logic [2:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;
  logic             busy;

  int tests  = 0;
  int failed = 0;

  seq_barrel_shifter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cnt    (in_cnt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full transaction: accept, fixed four-cycle latency, result, handshake.
  task automatic run_op(input string tag, input logic [2:0] mode, input logic [15:0] data,
                        input logic [3:0] cnt, input logic [15:0] exp, input logic exp_err);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_mode  = mode;
    in_data  = data;
    in_cnt   = cnt;
    tick();
    in_valid = 1'b0;
    check({tag, "_busy_accept"}, 32'(busy), 32'd1);
    check({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
    repeat (3) tick();
    check({tag, "_no_early_valid"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_out_data"}, 32'(out_data), 32'(exp));
    check({tag, "_out_err"}, 32'(out_err), 32'(exp_err));
    check({tag, "_busy_done"}, 32'(busy), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_clear"}, 32'(out_valid), 32'd0);
    check({tag, "_err_clear"}, 32'(out_err), 32'd0);
    check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_data_kept"}, 32'(out_data), 32'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_cnt    = '0;
    in_mode   = 3'b000;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_out_err", 32'(out_err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    // Basic modes and count boundaries
    run_op("srl_8001_15", 3'b001, 16'h8001, 4'd15, 16'h0001, 1'b0);
    run_op("sra_8000_3",  3'b010, 16'h8000, 4'd3,  16'hF000, 1'b0);
    run_op("sra_4000_3",  3'b010, 16'h4000, 4'd3,  16'h0800, 1'b0);
    run_op("sra_ffff_15", 3'b010, 16'hFFFF, 4'd15, 16'hFFFF, 1'b0);
    run_op("sll_0001_15", 3'b000, 16'h0001, 4'd15, 16'h8000, 1'b0);
    run_op("sll_ffff_4",  3'b000, 16'hFFFF, 4'd4,  16'hFFF0, 1'b0);
    run_op("rol_8001_4",  3'b011, 16'h8001, 4'd4,  16'h0018, 1'b0);
    run_op("ror_0001_1",  3'b100, 16'h0001, 4'd1,  16'h8000, 1'b0);
    run_op("ror_1234_8",  3'b100, 16'h1234, 4'd8,  16'h3412, 1'b0);
    run_op("rol_1234_0",  3'b011, 16'h1234, 4'd0,  16'h1234, 1'b0);
    run_op("sll_1234_0",  3'b000, 16'h1234, 4'd0,  16'h1234, 1'b0);

    // Backpressure in DONE with a competing request
    in_valid = 1'b1;
    in_mode  = 3'b001;
    in_data  = 16'hA5A5;
    in_cnt   = 4'd4;
    tick();
    in_data  = 16'h00F0;
    in_cnt   = 4'd4;
    in_mode  = 3'b000;
    repeat (4) tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data", 32'(out_data), 32'h0A5A);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_idle_ready", 32'(in_ready), 32'd1);
    check("bp_idle_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    check("bp_new_accept_busy", 32'(busy), 32'd1);
    check("bp_new_loaded", 32'(out_data), 32'h00F0);
    repeat (4) tick();
    check("bp_new_valid", 32'(out_valid), 32'd1);
    check("bp_new_data", 32'(out_data), 32'h0F00);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of SHIFT
    in_valid = 1'b1;
    in_mode  = 3'b000;
    in_data  = 16'h1111;
    in_cnt   = 4'd5;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_data", 32'(out_data), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (4) tick();
    check("abort_no_result", 32'(out_valid), 32'd0);

    // Reserved mode passes data through and flags an error
    run_op("rsvd_beef_7", 3'b101, 16'hBEEF, 4'd7, 16'hBEEF, 1'b1);
    run_op("srl_after_rsvd", 3'b001, 16'hBEEF, 4'd4, 16'h0BEE, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
